pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Programmable pulse-train generator: on a single-cycle `start` it drives `dout` with `num_pulses` high pulses of `high_len` cycles separated by `low_len` low cycles, then signals `done`. It is the producing end of the pulse path that `edge_detector` consumes. It supplies stimulus and strobes to edge-sensitive logic, and its `dout` feeds `edge_detector.din` in the paired block bench.

## Interface
- `CNT_W`, default 8: width of `num_pulses` and of the internal pulse counter.
- `LEN_W`, default 8: width of `high_len` and `low_len` and of the internal phase counter.

- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only while idle
- `abort`  in  1  synchronous cancel of a running train
- `num_pulses`  in  CNT_W  pulses per train, latched at start
- `high_len`  in  LEN_W  high-phase length in cycles, latched at start
- `low_len`  in  LEN_W  gap length in cycles, latched at start
- `dout`  out  1  registered pulse output
- `busy`  out  1  train in progress
- `done`  out  1  one-cycle completion strobe

## Operation
- FSM states: IDLE, HIGH, LOW. All outputs are registered.
- IDLE with `start`=1 and `num_pulses`≠0: latch the config, then go to HIGH with the pulse counter set to `num_pulses`.
- IDLE with `start`=1 and `num_pulses`=0: stay in IDLE and pulse `done` next cycle. `dout` and `busy` stay 0.
- A `high_len` or `low_len` of 0 is treated as 1. Config inputs are ignored outside IDLE.
- HIGH: `dout`=1 for the latched `high_len` cycles. At phase end, decrement the pulse counter.
  - If pulses remain, go to LOW.
  - Otherwise go to IDLE and assert `done` for 1 cycle.
- LOW: `dout`=0 for `low_len` cycles, then go to HIGH. No LOW phase follows the last pulse.
- `busy`=1 exactly while the state is HIGH or LOW.
- `start` while busy is ignored. It is not queued.
- `abort`=1 while busy: next cycle go to IDLE with `dout`=0 and `busy`=0. `done` is not asserted.
- `abort` takes priority over phase and counter transitions in the same cycle. `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` is accepted.
- Async reset: state IDLE, `dout`=0, `busy`=0, `done`=0, counters 0. Reset mid-train discards the train.

## Timing
- Cycle numbering: `start` sampled at the rising edge ending cycle 0.
- With H=`high_len`, L=`low_len`, N=`num_pulses`:
  - Pulse k (k=0..N-1) has `dout`=1 in cycles 1+k(H+L) through k(H+L)+H.
  - `busy`=1 in cycles 1 through T, where T = N·H + (N−1)·L.
  - `done`=1 in cycle T+1 only, with `busy`=0 and `dout`=0 in that cycle.
- `start` sampled in the `done` cycle is accepted, so back-to-back trains have exactly 1 idle cycle between them.
- Latency from `start` to the first `dout` high is 1 cycle. Latency from `abort` to `dout`/`busy` low is 1 cycle.
- Counter wrap: counters only decrement from non-zero values and never wrap. Maximum train: N=2^CNT_W−1, H=L=2^LEN_W−1.

## Structure
- Package `pulse_train_pkg`:
  - `ptg_state_t` enum {IDLE, HIGH, LOW}
  - default width localparams `PTG_CNT_W`=8 and `PTG_LEN_W`=8
- Sub-module `ptg_down_counter`: parameterised width, with `load`/`value`/`dec` inputs and a `zero` flag (`cnt`==1 or `cnt`==0).
  - Instance 1: phase length (H/L).
  - Instance 2: remaining pulses.
- The top level holds the FSM, the latched config and the output registers.

## Test plan
- Reset: hold `resetn`=0 with `start`=1 -> `dout`=`busy`=`done`=0 throughout. Release reset, then N=1, H=1, L=0 -> single 1-cycle `dout` pulse in cycle 1, `done` in cycle 2.
- Basic train: N=3, H=2, L=3 -> `dout` high in cycles 1–2, 6–7, 11–12; `busy` in cycles 1–12; `done` in cycle 13. Chained `edge_detector` counts 3 rising edges.
- Zero/clamp: N=0 -> `done` in cycle 1, `busy` never asserted. N=2, H=0, L=0 -> `dout` high in cycles 1 and 3, `done` in cycle 4.
- Ignored start and back-to-back: `start` with new config during cycle 4 of an N=2, H=2, L=2 train -> no effect. `start` in the `done` cycle -> new train's `dout` rises the following cycle.
- Abort: N=4, H=3, L=3, `abort` in cycle 5 -> `dout`=`busy`=0 from cycle 6, no `done`. Same-cycle `abort`+`start` in IDLE -> train starts.
- Async reset mid-train: deassert `resetn` during a HIGH phase -> `dout` drops immediately, with no clock edge required, and no `done` follows.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse-train generator.
package pulse_train_pkg;

    localparam int PTG_CNT_W = 8;
    localparam int PTG_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ptg_state_t;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/config/status bundle between a train requester and the generator.
interface pulse_train_gen_if
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W,
    parameter int LEN_W = PTG_LEN_W
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_pulses;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic             dout;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, num_pulses, high_len, low_len,
        input  dout, busy, done
    );

    modport slave (
        input  start, abort, num_pulses, high_len, low_len,
        output dout, busy, done
    );
endinterface

// File: rtl/pulse_train_gen_down_counter.sv
// Loadable down counter; 'zero' flags the final count (1) and also an
// empty load (0), so a zero-length phase behaves as a one-cycle phase.
module ptg_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] NONE = {W{1'b0}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; never decrement below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != NONE)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= NONE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q <= ONE);
endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H high cycles separated
// by L low cycles, then a one-cycle done strobe. All outputs registered.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W,
    parameter int LEN_W = PTG_LEN_W
) (
    input  logic             clk,
    input  logic             resetn,
    pulse_train_gen_if.slave bus
);
    ptg_state_t       state_q, state_d;
    logic [LEN_W-1:0] high_len_q, high_len_d;
    logic [LEN_W-1:0] low_len_q, low_len_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ph_load_s, ph_dec_s, ph_zero_s;
    logic [LEN_W-1:0] ph_val_s;
    logic             pc_load_s, pc_dec_s, pc_zero_s;

    // Phase-length counter (current HIGH or LOW phase).
    ptg_down_counter #(.W(LEN_W)) u_phase_cnt (
        .clk    (clk),
        .resetn (resetn),
        .load   (ph_load_s),
        .value  (ph_val_s),
        .dec    (ph_dec_s),
        .zero   (ph_zero_s)
    );

    // Remaining-pulse counter.
    ptg_down_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk    (clk),
        .resetn (resetn),
        .load   (pc_load_s),
        .value  (bus.num_pulses),
        .dec    (pc_dec_s),
        .zero   (pc_zero_s)
    );

    // Next-state, counter control and next-output decode; abort has priority.
    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        dout_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        ph_load_s  = 1'b0;
        ph_val_s   = high_len_q;
        ph_dec_s   = 1'b0;
        pc_load_s  = 1'b0;
        pc_dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_pulses != {CNT_W{1'b0}}) begin
                        high_len_d = bus.high_len;
                        low_len_d  = bus.low_len;
                        ph_load_s  = 1'b1;
                        ph_val_s   = bus.high_len;
                        pc_load_s  = 1'b1;
                        state_d    = HIGH;
                        dout_d     = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (ph_zero_s) begin
                    pc_dec_s = 1'b1;
                    if (pc_zero_s) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ph_load_s = 1'b1;
                        ph_val_s  = low_len_q;
                        state_d   = LOW;
                        busy_d    = 1'b1;
                    end
                end else begin
                    ph_dec_s = 1'b1;
                    dout_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (ph_zero_s) begin
                    ph_load_s = 1'b1;
                    ph_val_s  = high_len_q;
                    state_d   = HIGH;
                    dout_d    = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    ph_dec_s = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched config and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            high_len_q <= {LEN_W{1'b0}};
            low_len_q  <= {LEN_W{1'b0}};
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: expected per-cycle dout/busy/done
// are derived from the cycle-timing formulas when a train is launched and
// compared one entry per clock.
module tb_pulse_train_gen;

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    pulse_train_gen_if #(.CNT_W(8), .LEN_W(8)) bus ();

    pulse_train_gen #(.CNT_W(8), .LEN_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Push expectations for cycles from..to of a train started in cycle 0.
    task automatic push_range(input int n, input int h, input int l, input int from, input int to);
        int   hh, ll, t;
        exp_t e;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        t  = (n == 0) ? 0 : n * hh + (n - 1) * ll;
        for (int c = from; c <= to; c++) begin
            e.done = (c == t + 1);
            e.busy = (c >= 1) && (c <= t);
            e.dout = (c >= 1) && (c <= t) && (((c - 1) % (hh + ll)) < hh);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int k);
        exp_t e;
        e = 3'b000;
        for (int i = 0; i < k; i++) sb_q.push_back(e);
    endtask

    // One clock: sample 1 time unit after the edge and score one entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("dout", bus.dout, e.dout);
            chk("busy", bus.busy, e.busy);
            chk("done", bus.done, e.done);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 5000) begin
            tick();
            guard++;
        end
        chk("drain_bound", sb_q.size(), 0);
    endtask

    // kind: 0 plain, 1 start+new config at ev_cyc, 2 abort at ev_cyc,
    // 3 abort together with start in cycle 0.
    task automatic run_train(input int n, input int h, input int l, input int ev_cyc, input int kind);
        int hh, ll, t, c;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        t  = (n == 0) ? 0 : n * hh + (n - 1) * ll;
        bus.num_pulses = 8'(n);
        bus.high_len   = 8'(h);
        bus.low_len    = 8'(l);
        bus.start      = 1'b1;
        bus.abort      = (kind == 3);
        if (kind == 2) begin
            push_range(n, h, l, 1, ev_cyc);
            push_idle(3);
        end else begin
            push_range(n, h, l, 1, t + 1);
        end
        c = 0;
        while (sb_q.size() > 0 && c < 5000) begin
            tick();
            c++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (c == ev_cyc && kind == 1) begin
                bus.start      = 1'b1;
                bus.num_pulses = 8'd7;
                bus.high_len   = 8'd5;
                bus.low_len    = 8'd1;
            end
            if (c == ev_cyc && kind == 2) bus.abort = 1'b1;
        end
        chk("train_bound", sb_q.size(), 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        resetn         = 1'b0;
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.num_pulses = 8'd1;
        bus.high_len   = 8'd1;
        bus.low_len    = 8'd0;

        // Reset held with start high: everything stays low.
        push_idle(4);
        drain();
        resetn    = 1'b1;
        bus.start = 1'b0;
        push_idle(1);
        drain();

        run_train(1, 1, 0, 0, 0);   // single pulse, done in cycle 2
        push_idle(2);
        drain();
        run_train(3, 2, 3, 0, 0);   // basic train
        push_idle(2);
        drain();
        run_train(0, 5, 5, 0, 0);   // N=0: done only
        push_idle(2);
        drain();
        run_train(2, 0, 0, 0, 0);   // clamp H=L=0 to 1
        push_idle(2);
        drain();
        run_train(2, 2, 2, 4, 1);   // start in cycle 4 ignored
        run_train(2, 1, 1, 0, 0);   // back-to-back from done cycle
        push_idle(2);
        drain();
        run_train(4, 3, 3, 5, 2);   // abort in cycle 5
        run_train(2, 1, 2, 0, 3);   // abort+start in IDLE: accepted
        push_idle(2);
        drain();

        // Async reset during HIGH phase.
        bus.num_pulses = 8'd3;
        bus.high_len   = 8'd4;
        bus.low_len    = 8'd2;
        bus.start      = 1'b1;
        push_range(3, 4, 2, 1, 2);
        tick();
        bus.start = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_dout", bus.dout, 1'b0);
        chk("async_busy", bus.busy, 1'b0);
        chk("async_done", bus.done, 1'b0);
        push_idle(3);
        drain();
        resetn = 1'b1;
        push_idle(8);
        drain();
        run_train(1, 2, 0, 0, 0);   // recovers after reset
        push_idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
